// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state set, RV32I opcode
// values recognised by the decoder, and the ALU / immediate select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC,
    ALUWB,
    BRANCH,
    HALT
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// ALU operation decode for register and immediate arithmetic instructions.
// Only an R-type with Ins[30] set turns funct3=000 into a subtract; addi
// ignores that bit because it belongs to the immediate.
module alu_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct75_i,
  output logic [2:0] aluCtrl_o
);

  // Map funct3 (plus Ins[30] for R-type) onto the ALU control code.
  always_comb begin
    aluCtrl_o = ALU_ADD;
    case (funct3_i)
      3'b000: begin
        if ((op_i == OP_RTYPE) && funct75_i) begin
          aluCtrl_o = ALU_SUB;
        end
      end
      3'b010:  aluCtrl_o = ALU_SLT;
      3'b110:  aluCtrl_o = ALU_OR;
      3'b111:  aluCtrl_o = ALU_AND;
      default: aluCtrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle RV32I subset controller. Memory accesses are handshaked with
// mem_ready; the first FETCH cycle after reset never completes so that the
// instruction register is not loaded while reset is still settling.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       EQ,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCsrc,
  output logic       RegWrite,
  output logic       ResultSrc,
  output logic       ALUsrc,
  output logic [2:0] ALUctrl,
  output logic [1:0] ImmSrc,
  output logic       halted
);

  state_e     state_q;
  state_e     state_d;
  logic       fresh_q;
  logic [2:0] decAluCtrl;
  logic       isStore;
  logic       isImm;
  logic       brTaken;

  alu_ctrl_dec u_alu_dec (
    .op_i      (Op),
    .funct3_i  (funct3),
    .funct75_i (funct7_5),
    .aluCtrl_o (decAluCtrl)
  );

  assign isStore = (Op == OP_STORE);
  assign isImm   = (Op == OP_ITYPE);
  // Only beq/bne are supported; every other branch condition falls through.
  assign brTaken = (funct3[2:1] == 2'b00) && (funct3[0] ^ EQ);

  // State register; fresh_q marks the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      fresh_q <= 1'b1;
    end else begin
      state_q <= state_d;
      fresh_q <= 1'b0;
    end
  end

  // Next-state sequencing through the instruction phases.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ready && !fresh_q) state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_LOAD, OP_STORE:  state_d = MEMADR;
          OP_RTYPE, OP_ITYPE: state_d = EXEC;
          OP_BRANCH:          state_d = BRANCH;
          default:            state_d = HALT_ON_ILLEGAL ? HALT : FETCH;
        endcase
      end
      MEMADR: state_d = isStore ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_ready) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Datapath controls per phase; reset masks every enable but the request.
  always_comb begin
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    ALUsrc    = 1'b0;
    ALUctrl   = ALU_ADD;
    ImmSrc    = IMM_I;
    halted    = 1'b0;
    if (rst) begin
      mem_req = 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready && !fresh_q) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        MEMADR: begin
          ALUsrc  = 1'b1;
          ALUctrl = ALU_ADD;
          ImmSrc  = isStore ? IMM_S : IMM_I;
        end
        MEMRD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        MEMWB: begin
          RegWrite  = 1'b1;
          ResultSrc = 1'b1;
        end
        MEMWR: begin
          mem_req  = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        EXEC: begin
          ALUsrc  = isImm;
          ALUctrl = decAluCtrl;
        end
        ALUWB: begin
          ALUsrc   = isImm;
          ALUctrl  = decAluCtrl;
          RegWrite = 1'b1;
        end
        BRANCH: begin
          ALUctrl = ALU_SUB;
          ImmSrc  = IMM_B;
          PCsrc   = brTaken;
          PCWrite = brTaken;
        end
        HALT: halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule
